// File: rtl/aes_pkg.sv
// Shared AES sequencing constants: round count, phase codes, FSM states.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS_DEF = 10;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_INIT  = 2'd1;
  localparam logic [1:0] PH_FULL  = 2'd2;
  localparam logic [1:0] PH_FINAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/aes_round_timer.sv
// Loadable down-counter timing the cycles spent on one round index.
module aes_round_timer #(
  parameter int unsigned CYCLES = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW =
    (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/aes_inv_round_sequencer.sv
// Decryption round controller: walks key index NUM_ROUNDS..0
// and tells the inverse datapath which operations to apply.
module aes_inv_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS   = NUM_ROUNDS_DEF,
  parameter int unsigned ROUND_CYCLES = 7,
  parameter int unsigned IDX_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             keys_valid,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] key_rd_idx,
  output logic [1:0]       phase,
  output logic             round_strobe,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             abort
);

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_ROUNDS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             abort_q, abort_d;
  logic             t_load, t_en, tc;

  aes_round_timer #(
    .CYCLES(ROUND_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(t_load),
    .en  (t_en),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    abort_d      = 1'b0;
    t_load       = 1'b0;
    t_en         = 1'b0;
    in_ready     = 1'b0;
    busy         = 1'b0;
    phase        = PH_IDLE;
    round_strobe = 1'b0;
    out_valid    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = keys_valid;
        if (in_valid && keys_valid) begin
          state_d = ST_RUN;
          idx_d   = IDX_TOP;
          t_load  = 1'b1;
        end
      end
      ST_RUN: begin
        busy         = 1'b1;
        round_strobe = tc;
        unique case (1'b1)
          (idx_q == IDX_TOP): phase = PH_INIT;
          (idx_q == '0):      phase = PH_FINAL;
          default:            phase = PH_FULL;
        endcase
        if (!keys_valid) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          abort_d = 1'b1;
          t_load  = 1'b1;
        end else if (tc) begin
          t_load = 1'b1;
          // round 0 is the last one; never wrap the index
          if (idx_q == '0) state_d = ST_DONE;
          else idx_d = idx_q - IDX_W'(1);
        end else begin
          t_en = 1'b1;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end else if (!keys_valid) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign key_rd_idx = idx_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_aes_inv_round_sequencer.sv
// Bench for aes_inv_round_sequencer: randomized scenarios checked
// against a cycle-offset arithmetic model of the round schedule.
module tb_aes_inv_round_sequencer;

  logic clk;
  logic rst;
  logic kv, iv, ov_rdy;
  logic kv2, iv2, ov_rdy2;

  logic       in_ready, round_strobe, busy, out_valid, abort;
  logic [3:0] key_rd_idx;
  logic [1:0] phase;
  logic       in_ready2, round_strobe2, busy2, out_valid2, abort2;
  logic [3:0] key_rd_idx2;
  logic [1:0] phase2;

  int errors = 0;
  int checks = 0;

  aes_inv_round_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .keys_valid  (kv),
    .in_valid    (iv),
    .in_ready    (in_ready),
    .key_rd_idx  (key_rd_idx),
    .phase       (phase),
    .round_strobe(round_strobe),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (ov_rdy),
    .abort       (abort)
  );

  aes_inv_round_sequencer #(
    .NUM_ROUNDS  (14),
    .ROUND_CYCLES(1),
    .IDX_W       (4)
  ) dut14 (
    .clk         (clk),
    .rst         (rst),
    .keys_valid  (kv2),
    .in_valid    (iv2),
    .in_ready    (in_ready2),
    .key_rd_idx  (key_rd_idx2),
    .phase       (phase2),
    .round_strobe(round_strobe2),
    .busy        (busy2),
    .out_valid   (out_valid2),
    .out_ready   (ov_rdy2),
    .abort       (abort2)
  );

  logic [10:0] obs, obs14;
  assign obs = {busy, in_ready, key_rd_idx, phase,
                round_strobe, out_valid, abort};
  assign obs14 = {busy2, in_ready2, key_rd_idx2, phase2,
                  round_strobe2, out_valid2, abort2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs t cycles after the accepting edge.
  function automatic logic [10:0] exp_run(int t, int nr, int rc);
    int total;
    int idx;
    logic [1:0] ph;
    logic stb;
    total = (nr + 1) * rc;
    if (t > total)
      return {1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    idx = nr - (t - 1) / rc;
    if (idx == nr) ph = 2'd1;
    else if (idx == 0) ph = 2'd3;
    else ph = 2'd2;
    stb = ((t % rc) == 0);
    return {1'b1, 1'b0, 4'(idx), ph, stb, 1'b0, 1'b0};
  endfunction

  function automatic logic [10:0] exp_idle(logic k, logic ab);
    return {1'b0, k, 4'd0, 2'd0, 1'b0, 1'b0, ab};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    iv = 1'b1;
    tick();
    iv = 1'b0;
  endtask

  task automatic run_to(input string nm, input int t0, input int t1);
    for (int t = t0; t <= t1; t++) begin
      if (t > t0) tick();
      checks++;
      if (obs !== exp_run(t, 10, 7)) begin
        errors++;
        $display("FAIL %s t=%0d got=%h exp=%h",
                 nm, t, obs, exp_run(t, 10, 7));
      end
    end
  endtask

  task automatic check_idle(input string nm, input logic ab);
    checks++;
    if (obs !== exp_idle(kv, ab)) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, obs, exp_idle(kv, ab));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== exp_idle(1'b1, 1'b0)) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs, exp_idle(1'b1, 1'b0));
    end
    checks++;
    if (dut.u_timer.cnt !== 3'd6) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=6", dut.u_timer.cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    ov_rdy = 1'b1;
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 5)) tick();
      start();
      run_to("nominal", 1, 78);
      tick();
      check_idle("nominal_end", 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int hold;
    hold = 20 + $urandom_range(0, 5);
    ov_rdy = 1'b0;
    start();
    run_to("bp_run", 1, 78);
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (obs !== exp_run(78, 10, 7)) begin
        errors++;
        $display("FAIL bp_hold i=%0d got=%h exp=%h",
                 i, obs, exp_run(78, 10, 7));
      end
    end
    ov_rdy = 1'b1;
    iv = 1'b1;
    tick();
    check_idle("bp_handoff", 1'b0);
    tick();
    iv = 1'b0;
    run_to("b2b_run", 1, 78);
    tick();
    check_idle("b2b_end", 1'b0);
  endtask

  task automatic test_gating();
    kv = 1'b0;
    iv = 1'b1;
    repeat ($urandom_range(2, 6)) begin
      tick();
      check_idle("gate_hold", 1'b0);
    end
    kv = 1'b1;
    #1;
    check_idle("gate_rdy", 1'b0);
    tick();
    iv = 1'b0;
    run_to("gate_run", 1, 78);
    tick();
    check_idle("gate_end", 1'b0);
  endtask

  task automatic test_abort();
    int ta;
    ta = 5 * 7 + 1 + $urandom_range(0, 6);
    start();
    run_to("ab_run", 1, ta);
    kv = 1'b0;
    tick();
    check_idle("ab_pulse", 1'b1);
    tick();
    check_idle("ab_after", 1'b0);
    kv = 1'b1;
    tick();
    ov_rdy = 1'b0;
    start();
    run_to("ab_done_run", 1, 78);
    kv = 1'b0;
    tick();
    check_idle("ab_done", 1'b1);
    kv = 1'b1;
    tick();
    start();
    run_to("ab_ho_run", 1, 78);
    ov_rdy = 1'b1;
    kv = 1'b0;
    tick();
    check_idle("ab_handoff", 1'b0);
    kv = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int t3;
    t3 = 7 * 7 + 1 + $urandom_range(0, 6);
    start();
    run_to("rm_run", 1, t3);
    rst = 1'b1;
    tick();
    check_idle("rm_reset", 1'b0);
    checks++;
    if (dut.u_timer.cnt !== 3'd6) begin
      errors++;
      $display("FAIL rm_cnt got=%0d exp=6", dut.u_timer.cnt);
    end
    rst = 1'b0;
    start();
    run_to("rm_rerun", 1, 78);
    tick();
    check_idle("rm_end", 1'b0);
  endtask

  task automatic test_corner();
    iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      if (t > 1) tick();
      checks++;
      if (obs14 !== exp_run(t, 14, 1)) begin
        errors++;
        $display("FAIL corner t=%0d got=%h exp=%h",
                 t, obs14, exp_run(t, 14, 1));
      end
    end
    tick();
    checks++;
    if (obs14 !== exp_idle(kv2, 1'b0)) begin
      errors++;
      $display("FAIL corner_end got=%h exp=%h",
               obs14, exp_idle(kv2, 1'b0));
    end
  endtask

  initial begin
    rst = 1'b1;
    kv = 1'b1;
    iv = 1'b0;
    ov_rdy = 1'b1;
    kv2 = 1'b1;
    iv2 = 1'b0;
    ov_rdy2 = 1'b1;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_gating();
    test_abort();
    test_reset_mid();
    test_corner();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
